vga_sync_rx: RTL and testbench
==============================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 SHALL have parameter H_START, default 144, meaning clocks from HS falling edge to first active pixel (sync 96 + back porch 48).
REQ-002 SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-003 SHALL have parameter V_START, default 35, meaning lines from VS falling edge to first active line (sync 2 + back porch 33).
REQ-004 SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-005 SHALL have port CLK  input  1  pixel clock; all logic on rising edge; single clock domain.
REQ-006 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port HS  input  1  horizontal sync, active low, pixel-clock synchronous.
REQ-008 SHALL have port VS  input  1  vertical sync, active low, pixel-clock synchronous.
REQ-009 SHALL have port PIX  input  8  pixel data {R[2:0],G[2:0],B[1:0]}.
REQ-010 SHALL have port x  output  10  recovered column, 0..H_ACTIVE-1.
REQ-011 SHALL have port y  output  10  recovered row, 0..V_ACTIVE-1.
REQ-012 SHALL have port de  output  1  data enable; x, y, pix_out valid when high.
REQ-013 SHALL have port pix_out  output  8  PIX delayed to align with x/y/de.
REQ-014 SHALL have port frame_start  output  1  one-cycle pulse on each detected VS falling edge.
REQ-015 SHALL have port locked  output  1  stable timing detected.
REQ-016 SHALL have port h_total  output  11  last measured clocks per line.
REQ-017 SHALL have port v_total  output  11  last measured lines per frame.

Function
REQ-018 SHALL register HS, VS, PIX once (stage 1) and detect falling edges by comparing stage 1 against a stage 2 copy.
REQ-019 SHALL hold hcnt (11 bit): cleared to 0 on the cycle an HS falling edge is detected, else incremented, saturating at 2047.
REQ-020 SHALL, on each HS falling edge, latch h_total = hcnt+1 (saturated 2047) into a candidate register.
REQ-021 SHALL hold vcnt (11 bit): cleared to 0 on a VS falling edge, incremented on each HS falling edge otherwise, saturating at 2047; simultaneous HS and VS falling edges -> vcnt = 0.
REQ-022 SHALL, on each VS falling edge, latch v_total = vcnt+1 and pulse frame_start one cycle later than the edge detection.
REQ-023 SHALL assert de when H_START <= hcnt < H_START+H_ACTIVE and V_START <= vcnt < V_START+V_ACTIVE and locked = 1, with x = hcnt-H_START, y = vcnt-V_START.
REQ-024 SHALL produce de/x/y/pix_out registered, exactly 3 CLK cycles after PIX at the input; x/y SHALL be 0 whenever de = 0.
REQ-025 SHALL implement lock FSM states UNLOCKED, ACQUIRE, LOCKED.
REQ-026 UNLOCKED -> ACQUIRE on first VS falling edge; ACQUIRE stores h_total/v_total reference.
REQ-027 ACQUIRE -> LOCKED on next VS falling edge when h_total and v_total both equal the reference; mismatch -> remain ACQUIRE with reference updated.
REQ-028 LOCKED -> UNLOCKED on any HS falling edge with measured line length differing from reference, or any VS falling edge with differing v_total, or hcnt reaching 2047 (sync lost).
REQ-029 locked SHALL be 1 only in LOCKED; exit from LOCKED forces de = 0 from the next cycle.

Reset
REQ-030 SHALL, while RST_N = 0, asynchronously force: FSM UNLOCKED, hcnt = vcnt = 0, h_total = v_total = 0, de = 0, x = y = 0, pix_out = 0, frame_start = 0, locked = 0, sync stages = 1 (idle high).
REQ-031 SHALL resume from UNLOCKED after RST_N deassertion mid-frame, requiring two full frames before locked = 1.

Verification
REQ-032 Two identical 800x525 frames (640x480@60 timing) -> locked rises one cycle after second VS falling edge; h_total = 800, v_total = 525.
REQ-033 Locked third frame, PIX = pixel column LSBs -> first de cycle has x = 0, y = 0, pix_out = PIX from 3 cycles earlier; exactly 307200 de cycles per frame; last has x = 639, y = 479.
REQ-034 Locked, one line shortened to 799 clocks -> locked = 0 and de = 0 from that HS edge; relock after two consistent frames.
REQ-035 HS held high 3000 clocks -> hcnt saturates 2047, locked = 0, no de.
REQ-036 RST_N pulsed low for 2 cycles mid-active-line -> all outputs 0 asynchronously; locked stays 0 until two further full frames.
REQ-037 HS and VS falling on the same cycle -> vcnt = 0, frame_start pulses once, v_total latched correctly.

Source files
------------

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers pixel coordinates from HS/VS and
// measures line/frame timing behind a three-state lock tracker.
module vga_sync_rx #(
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        HS,
    input  logic        VS,
    input  logic [7:0]  PIX,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic [7:0]  pix_out,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] h_total,
    output logic [10:0] v_total
);

    localparam logic [10:0] CMAX = 11'd2047;
    localparam logic [10:0] H_LO = 11'(H_START);
    localparam logic [10:0] H_HI = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] V_LO = 11'(V_START);
    localparam logic [10:0] V_HI = 11'(V_START + V_ACTIVE);

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED
    } lock_t;

    lock_t       state;
    lock_t       state_d;
    logic        hs1;
    logic        hs2;
    logic        vs1;
    logic        vs2;
    logic [7:0]  pix1;
    logic [7:0]  pix2;
    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic [10:0] ref_h;
    logic [10:0] ref_v;
    logic [10:0] h_meas;
    logic [10:0] v_meas;
    logic [10:0] h_cur;
    logic        hs_fall;
    logic        vs_fall;
    logic        ref_load;
    logic        win;
    logic        de_d;

    assign hs_fall = hs2 & ~hs1;
    assign vs_fall = vs2 & ~vs1;
    assign h_meas  = (hcnt == CMAX) ? CMAX : hcnt + 11'd1;
    assign v_meas  = (vcnt == CMAX) ? CMAX : vcnt + 11'd1;
    // line length as seen this cycle, including a line ending right now
    assign h_cur   = hs_fall ? h_meas : h_total;
    assign win     = (hcnt >= H_LO) && (hcnt < H_HI) &&
                     (vcnt >= V_LO) && (vcnt < V_HI);
    assign locked  = (state == LOCKED);
    assign de_d    = win && (state_d == LOCKED);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hs1  <= 1'b1;
            hs2  <= 1'b1;
            vs1  <= 1'b1;
            vs2  <= 1'b1;
            pix1 <= '0;
            pix2 <= '0;
        end else begin
            hs1  <= HS;
            hs2  <= hs1;
            vs1  <= VS;
            vs2  <= vs1;
            pix1 <= PIX;
            pix2 <= pix1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hcnt        <= '0;
            vcnt        <= '0;
            h_total     <= '0;
            v_total     <= '0;
            frame_start <= 1'b0;
        end else begin
            if (hs_fall)
                hcnt <= '0;
            else if (hcnt != CMAX)
                hcnt <= hcnt + 11'd1;
            if (vs_fall)
                vcnt <= '0;
            else if (hs_fall && vcnt != CMAX)
                vcnt <= vcnt + 11'd1;
            if (hs_fall)
                h_total <= h_meas;
            if (vs_fall)
                v_total <= v_meas;
            frame_start <= vs_fall;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= UNLOCKED;
        else
            state <= state_d;
    end

    always_comb begin
        state_d  = state;
        ref_load = 1'b0;
        unique case (state)
            UNLOCKED: begin
                if (vs_fall) begin
                    state_d  = ACQUIRE;
                    ref_load = 1'b1;
                end
            end
            ACQUIRE: begin
                if (vs_fall) begin
                    if (h_cur == ref_h && v_meas == ref_v)
                        state_d = LOCKED;
                    else
                        ref_load = 1'b1;
                end
            end
            LOCKED: begin
                if ((hs_fall && h_meas != ref_h) ||
                    (vs_fall && v_meas != ref_v) ||
                    (hcnt == CMAX))
                    state_d = UNLOCKED;
            end
            default: state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ref_h <= '0;
            ref_v <= '0;
        end else if (ref_load) begin
            ref_h <= h_cur;
            ref_v <= v_meas;
        end
    end

    // de is gated by the next lock state so an unlock blanks it at once
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            de      <= 1'b0;
            x       <= '0;
            y       <= '0;
            pix_out <= '0;
        end else begin
            de      <= de_d;
            x       <= de_d ? 10'(hcnt - H_LO) : '0;
            y       <= de_d ? 10'(vcnt - V_LO) : '0;
            pix_out <= pix2;
        end
    end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Randomized bench for vga_sync_rx on a shrunken raster,
// checked cycle by cycle against an event-level timing model.
module tb_vga_sync_rx;

    localparam int HST   = 8;
    localparam int HAC   = 16;
    localparam int VST   = 3;
    localparam int VAC   = 6;
    localparam int LINE  = 30;
    localparam int LINES = 12;
    localparam int HSW   = 4;
    localparam int VSW   = 2;

    localparam int M_HUNT = 0;
    localparam int M_ACQ  = 1;
    localparam int M_LOCK = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        HS = 1'b1;
    logic        VS = 1'b1;
    logic [7:0]  PIX = '0;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de;
    logic [7:0]  pix_out;
    logic        frame_start;
    logic        locked;
    logic [10:0] h_total;
    logic [10:0] v_total;

    vga_sync_rx #(
        .H_START (HST),
        .H_ACTIVE(HAC),
        .V_START (VST),
        .V_ACTIVE(VAC)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .HS         (HS),
        .VS         (VS),
        .PIX        (PIX),
        .x          (x),
        .y          (y),
        .de         (de),
        .pix_out    (pix_out),
        .frame_start(frame_start),
        .locked     (locked),
        .h_total    (h_total),
        .v_total    (v_total)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int         k;
        int         j;
        bit         lk;
        bit         vf;
        int         ht;
        int         vt;
        logic [7:0] pix;
        bit         win;
    } rec_t;

    // per-sample view: clocks since HS fell, lines since VS fell, lock mode
    rec_t q[$];
    int   mk, mj, mode, mht, mvt, mrh, mrv;
    bit   mphs, mpvs;

    int de_cnt, fs_cnt, first_x, first_y, last_x, last_y;
    bit seen;

    task automatic model(input logic h, input logic v,
                         input logic [7:0] p, input bit keep);
        bit   hf, vf;
        int   hlen, vlen, cur_h;
        rec_t r;
        hf    = mphs && !h;
        vf    = mpvs && !v;
        hlen  = (mk + 1 > 2047) ? 2047 : mk + 1;
        vlen  = (mj + 1 > 2047) ? 2047 : mj + 1;
        cur_h = hf ? hlen : mht;
        if (mode == M_HUNT) begin
            if (vf) begin
                mode = M_ACQ;
                mrh  = cur_h;
                mrv  = vlen;
            end
        end else if (mode == M_ACQ) begin
            if (vf) begin
                if (cur_h == mrh && vlen == mrv) begin
                    mode = M_LOCK;
                end else begin
                    mrh = cur_h;
                    mrv = vlen;
                end
            end
        end else begin
            if ((hf && hlen != mrh) || (vf && vlen != mrv) || mk == 2047)
                mode = M_HUNT;
        end
        mht = cur_h;
        if (vf) mvt = vlen;
        if (hf) mk = 0;
        else if (mk < 2047) mk = mk + 1;
        if (vf) mj = 0;
        else if (hf && mj < 2047) mj = mj + 1;
        mphs = h;
        mpvs = v;
        if (keep) begin
            r.k   = mk;
            r.j   = mj;
            r.lk  = (mode == M_LOCK);
            r.vf  = vf;
            r.ht  = mht;
            r.vt  = mvt;
            r.pix = p;
            r.win = mk >= HST && mk < HST + HAC && mj >= VST && mj < VST + VAC;
            q.push_back(r);
            if (q.size() > 3) void'(q.pop_front());
        end
    endtask

    // the cycle right after reset clocks idle stage values, then the held inputs
    task automatic model_reset();
        mk = 0; mj = 0; mode = M_HUNT;
        mht = 0; mvt = 0; mrh = 0; mrv = 0;
        mphs = 1'b1; mpvs = 1'b1;
        q.delete();
        model(1'b1, 1'b1, 8'd0, 1'b0);
        model(HS, VS, PIX, 1'b1);
    endtask

    task automatic step(input logic h, input logic v, input logic [7:0] p);
        rec_t a, b;
        bit   ede;
        @(negedge CLK);
        if (q.size() == 3) begin
            a   = q[0];
            b   = q[1];
            ede = a.win && b.lk;
            chk("locked", locked, b.lk);
            chk("de", de, ede);
            chk("x", x, ede ? a.k - HST : 0);
            chk("y", y, ede ? a.j - VST : 0);
            chk("pix_out", pix_out, a.pix);
            chk("frame_start", frame_start, b.vf);
            chk("h_total", h_total, b.ht);
            chk("v_total", v_total, b.vt);
        end
        if (de) begin
            de_cnt++;
            if (!seen) begin
                first_x = x;
                first_y = y;
                seen    = 1'b1;
            end
            last_x = x;
            last_y = y;
        end
        if (frame_start) fs_cnt++;
        HS  = h;
        VS  = v;
        PIX = p;
        model(h, v, p, 1'b1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_de"}, de, 0);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_pix"}, pix_out, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_ht"}, h_total, 0);
        chk({tag, "_vt"}, v_total, 0);
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk_zero("async_rst");
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic clear_stats();
        de_cnt = 0; fs_cnt = 0; seen = 1'b0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    endtask

    task automatic send_line(input int len, input bit vlow, input int rst_at);
        for (int p = 0; p < len; p++) begin
            if (p == rst_at) pulse_reset();
            step(p < HSW ? 1'b0 : 1'b1, vlow ? 1'b0 : 1'b1, 8'($urandom));
        end
    endtask

    task automatic send_frame(input int odd_line, input int odd_len,
                              input int rst_line, input int rst_pix);
        for (int l = 0; l < LINES; l++)
            send_line(l == odd_line ? odd_len : LINE, l < VSW,
                      l == rst_line ? rst_pix : -1);
    endtask

    initial begin
        clear_stats();
        #7;
        chk_zero("reset");
        release_reset();

        repeat (2) send_frame(-1, 0, -1, -1);
        chk("acq_not_locked", locked, 0);
        clear_stats();
        send_frame(-1, 0, -1, -1);
        chk("lock_after_2f", locked, 1);
        chk("lock_h_total", h_total, LINE);
        chk("lock_v_total", v_total, LINES);
        chk("de_per_frame", de_cnt, HAC * VAC);
        chk("first_x", first_x, 0);
        chk("first_y", first_y, 0);
        chk("last_x", last_x, HAC - 1);
        chk("last_y", last_y, VAC - 1);
        chk("fs_once", fs_cnt, 1);

        send_frame(5, LINE - 1, -1, -1);
        chk("short_unlock", locked, 0);
        send_frame(-1, 0, -1, -1);
        chk("relock_pending", locked, 0);
        send_frame(-1, 0, -1, -1);
        chk("relock", locked, 1);

        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 2) == 0)
                send_frame($urandom_range(0, LINES - 1),
                           $urandom_range(LINE - 2, LINE + 2), -1, -1);
            else
                send_frame(-1, 0, -1, -1);
        end
        repeat (3) send_frame(-1, 0, -1, -1);
        chk("rand_relock", locked, 1);

        clear_stats();
        repeat (3000) step(1'b1, 1'b1, 8'($urandom));
        chk("idle_de", de_cnt, 0);
        chk("idle_unlock", locked, 0);
        send_line(LINE, 1'b0, -1);
        chk("sat_h_total", h_total, 2047);
        repeat (3) send_frame(-1, 0, -1, -1);
        chk("idle_relock", locked, 1);

        send_frame(-1, 0, 5, 12);
        chk("rst_unlocked", locked, 0);
        repeat (2) send_frame(-1, 0, -1, -1);
        chk("rst_hold_2f", locked, 0);
        send_frame(-1, 0, -1, -1);
        chk("rst_relock", locked, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
